// File: rtl/sev_seg_scan_ctrl_if.sv
// Bus between the I/O port 0x81 register and the seven-segment scan controller.
// The host drives value/mode/strobe; the controller returns busy and the display pins.
interface sev_seg_scan_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] DATA_IN;
    logic              MODE;
    logic              LOAD;
    logic              BUSY;
    logic [7:0]        CATHODES;
    logic [3:0]        ANODES;

    modport master (
        output DATA_IN, MODE, LOAD,
        input  BUSY, CATHODES, ANODES
    );

    modport slave (
        input  DATA_IN, MODE, LOAD,
        output BUSY, CATHODES, ANODES
    );
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// 4-digit common-anode display controller: hex or unsigned decimal (sequential
// double-dabble), leading-zero blanking, overflow dashes, multiplexed refresh.
module sev_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int DATA_W      = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    sev_seg_scan_ctrl_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t              state, state_nxt;
    logic [19:0]         bcd, bcd_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [3:0]          bit_cnt;
    logic [3:0][3:0]     digit;
    logic                dec_mode;
    logic                ovf;
    logic [CNT_W-1:0]    refresh_cnt;
    logic [1:0]          idx;
    logic                lead_zero;
    logic [7:0]          cath_nxt;
    logic [7:0]          cath_p1;
    logic [3:0]          anode_p1;
    logic                load_hex, load_dec;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
        endcase
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign load_hex = (state == S_IDLE) && bus.LOAD &&  bus.MODE;
    assign load_dec = (state == S_IDLE) && bus.LOAD && !bus.MODE;
    assign bcd_nxt  = dabble_adj(bcd);
    assign bus.BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load_dec) state_nxt = S_CONV;
            S_CONV:   if (bit_cnt == 4'(DATA_W - 1)) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                 bit_cnt <= '0;
        else if (load_dec)         bit_cnt <= '0;
        else if (state == S_CONV)  bit_cnt <= bit_cnt + 4'd1;
    end

    // Conversion datapath: only meaningful between a decimal load and COMMIT.
    always_ff @(posedge CLK) begin
        if (load_dec) begin
            bcd   <= '0;
            shreg <= bus.DATA_IN;
        end else if (state == S_CONV) begin
            {bcd, shreg} <= {bcd_nxt[18:0], shreg, 1'b0};
        end
    end

    // Displayed value only changes on a hex load or at COMMIT, all digits at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            digit    <= '0;
            dec_mode <= 1'b0;
            ovf      <= 1'b0;
        end else if (load_hex) begin
            for (int i = 0; i < 4; i++) digit[i] <= bus.DATA_IN[4*i +: 4];
            dec_mode <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == S_COMMIT) begin
            for (int i = 0; i < 4; i++) digit[i] <= bcd[4*i +: 4];
            dec_mode <= 1'b1;
            ovf      <= (bcd[19:16] != 4'd0);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        lead_zero = 1'b0;
        case (idx)
            2'd3: lead_zero = (digit[3] == 4'd0);
            2'd2: lead_zero = (digit[3] == 4'd0) && (digit[2] == 4'd0);
            2'd1: lead_zero = (digit[3] == 4'd0) && (digit[2] == 4'd0) && (digit[1] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
        if (ovf)                        cath_nxt = 8'hBF;
        else if (dec_mode && lead_zero) cath_nxt = 8'hFF;
        else                            cath_nxt = seg7(digit[idx]);
    end

    // Output register stage: anode and cathode pattern move together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            anode_p1 <= 4'hE;
            cath_p1  <= 8'hC0;
        end else begin
            anode_p1 <= ~(4'b0001 << idx);
            cath_p1  <= cath_nxt;
        end
    end

    assign bus.ANODES   = anode_p1;
    assign bus.CATHODES = cath_p1;
endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Scoreboard bench for sev_seg_scan_ctrl: stimulus pushes expected display frames,
// a monitor pops them and checks busy timing, held digits and the scanned result.
module tb_sev_seg_scan_ctrl;
    localparam int DIV = 4;

    typedef struct packed {
        logic            is_dec;
        logic [3:0][7:0] cath;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_until = -1;
    bit   mon_busy = 1'b0;
    exp_t sb[$];
    logic [3:0][7:0] cur_frame;

    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam logic [3:0] AN_SEQ [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    sev_seg_scan_ctrl_if #(.DATA_W(16)) bus ();

    sev_seg_scan_ctrl #(.REFRESH_DIV(DIV), .DATA_W(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Reference: what the four digit positions must show for a given load.
    function automatic logic [3:0][7:0] frame_of(input logic [15:0] v, input logic mode);
        logic [3:0][7:0] f;
        int pw;
        int val;
        val = int'(v);
        pw  = 1;
        for (int i = 0; i < 4; i++) begin
            if (mode)              f[i] = SEG[(val >> (4*i)) & 15];
            else if (val > 9999)   f[i] = 8'hBF;
            else if (i > 0 && val < pw) f[i] = 8'hFF;
            else                   f[i] = SEG[(val / pw) % 10];
            pw = pw * 10;
        end
        return f;
    endfunction

    function automatic int an_index(input logic [3:0] an);
        case (an)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic scan_check(input logic [3:0][7:0] req, input string tag);
        logic [3:0][7:0] seen;
        logic [3:0]      got;
        bit              onehot;
        int              k;
        seen   = '0;
        got    = '0;
        onehot = 1'b1;
        repeat (4*DIV + 2) begin
            @(negedge CLK);
            k = an_index(bus.ANODES);
            if (k < 0) onehot = 1'b0;
            else begin
                seen[k] = bus.CATHODES;
                got[k]  = 1'b1;
            end
        end
        chk({tag, "_onehot"}, 32'(onehot), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!got[i] || seen[i] !== req[i]) begin
                failures++;
                $display("FAIL %s_digit%0d act=%0h req=%0h seen=%0b", tag, i, seen[i], req[i], got[i]);
            end
        end
    endtask

    // Caller must be just after a negedge; the load hits the next posedge.
    task automatic do_load(input logic [15:0] v, input logic mode);
        int   edge_n;
        exp_t e;
        edge_n = cyc + 1;
        bus.DATA_IN = v;
        bus.MODE    = mode;
        bus.LOAD    = 1'b1;
        if (edge_n > busy_until) begin
            if (!mode) busy_until = edge_n + 17;
            e.is_dec = !mode;
            e.cath   = frame_of(v, mode);
            mon_busy = 1'b1;
            sb.push_back(e);
        end
        @(posedge CLK);
        @(negedge CLK);
        bus.LOAD = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout act=busy req=idle");
        end
        @(negedge CLK);
    endtask

    // Monitor: one expected frame per accepted load.
    initial begin
        exp_t e;
        int   n;
        int   k;
        bit   hold_ok;
        forever begin
            wait (sb.size() != 0);
            e = sb.pop_front();
            mon_busy = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            if (e.is_dec) begin
                n = 0;
                hold_ok = 1'b1;
                while (bus.BUSY === 1'b1 && n < 40) begin
                    k = an_index(bus.ANODES);
                    if (k < 0 || bus.CATHODES !== cur_frame[k]) hold_ok = 1'b0;
                    n++;
                    @(negedge CLK);
                end
                chk("busy_cycles", 32'(n), 32'd17);
                chk("old_digits_held", 32'(hold_ok), 32'd1);
                @(negedge CLK);
                scan_check(e.cath, "dec");
            end else begin
                chk("hex_busy", 32'(bus.BUSY), 32'd0);
                @(negedge CLK);
                scan_check(e.cath, "hex");
            end
            cur_frame = e.cath;
            mon_busy  = 1'b0;
        end
    end

    initial begin
        logic [15:0] v;
        logic        m;
        int          sel;
        cur_frame   = {4{8'hC0}};
        bus.DATA_IN = '0;
        bus.MODE    = 1'b0;
        bus.LOAD    = 1'b0;
        RESET       = 1'b1;
        #1;
        chk("rst_anodes", 32'(bus.ANODES), 32'hE);
        chk("rst_cathodes", 32'(bus.CATHODES), 32'hC0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        repeat (3) @(negedge CLK);
        chk("rst_hold_anodes", 32'(bus.ANODES), 32'hE);
        RESET = 1'b0;

        // Scan sequence straight out of reset.
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            chk($sformatf("scan_an_%0d", n), 32'(bus.ANODES), 32'(AN_SEQ[((n - 1) / 4) % 4]));
            chk($sformatf("scan_cath_%0d", n), 32'(bus.CATHODES), 32'hC0);
        end

        do_load(16'hBEEF, 1'b1); wait_idle();
        do_load(16'd1234, 1'b0); wait_idle();
        do_load(16'd42, 1'b0);   wait_idle();
        do_load(16'd0, 1'b0);    wait_idle();
        do_load(16'd10000, 1'b0); wait_idle();
        do_load(16'hFFFF, 1'b0); wait_idle();
        do_load(16'd9999, 1'b0); wait_idle();

        // Second load while converting is dropped.
        do_load(16'd500, 1'b0);
        repeat (4) @(negedge CLK);
        do_load(16'd7, 1'b0);
        wait_idle();

        // Load landing on the COMMIT edge is dropped too.
        do_load(16'd321, 1'b0);
        repeat (16) @(negedge CLK);
        do_load(16'h1234, 1'b1);
        wait_idle();

        for (int t = 0; t < 24; t++) begin
            m   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      v = 16'($urandom);
            else if (sel == 1) v = 16'($urandom_range(0, 9999));
            else               v = 16'($urandom_range(0, 99));
            do_load(v, m);
            wait_idle();
        end

        // Reset in the middle of a conversion.
        bus.DATA_IN = 16'd1234;
        bus.MODE    = 1'b0;
        bus.LOAD    = 1'b1;
        @(negedge CLK);
        bus.LOAD = 1'b0;
        repeat (7) @(negedge CLK);
        chk("conv_busy_before_rst", 32'(bus.BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.BUSY), 32'd0);
        chk("midrst_anodes", 32'(bus.ANODES), 32'hE);
        chk("midrst_cathodes", 32'(bus.CATHODES), 32'hC0);
        @(negedge CLK);
        RESET = 1'b0;
        busy_until = -1;
        cur_frame  = {4{8'hC0}};
        repeat (20) @(negedge CLK);
        chk("after_rst_busy", 32'(bus.BUSY), 32'd0);
        scan_check({4{8'hC0}}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
